// File: rtl/lock_pkg.sv
// Shared definitions for the hardware-lock key path: loader states, key
// geometry and the key slices handed to each locked decoder stage.
// The CHECK state exists only when LOCK_KEY_CHECKSUM_EN is defined.
package lock_pkg;

    localparam int unsigned LOCK_NBYTES    = 8;
    localparam int unsigned LOCK_KEY_WIDTH = LOCK_NBYTES * 8;
    localparam int unsigned LOCK_MAX_FAIL  = 3;

    // Key slice feeding the ALU decoder
    localparam int unsigned ALU_KEY_LSB = 0;
    localparam int unsigned ALU_KEY_MSB = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_LOCKOUT
`ifdef LOCK_KEY_CHECKSUM_EN
        , ST_CHECK
`endif
    } lock_state_e;

    // Extract the ALU decoder's key byte from a full key bus
    function automatic logic [7:0] alu_key_slice(input logic [LOCK_KEY_WIDTH-1:0] key);
        return key[ALU_KEY_MSB:ALU_KEY_LSB];
    endfunction

endpackage

// File: rtl/lock_key_xor_acc.sv
// Running XOR of key bytes. A simultaneous clear and enable restarts the
// accumulation with the incoming byte, so the first byte of a load needs
// no extra cycle.
module lock_key_xor_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 8'h00;
        end else if (clr || en) begin
            acc <= (clr ? 8'h00 : acc) ^ (en ? din : 8'h00);
        end
    end

endmodule

// File: rtl/lock_key_loader.sv
// Byte-serial hardware-lock key loader. Bytes arrive LSB first into a
// shadow register; key_out only ever shows a fully committed key.
// Optional feature: LOCK_KEY_CHECKSUM_EN adds an XOR checksum byte after
// the key, with a failure counter and permanent lockout.
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = LOCK_KEY_WIDTH,
    parameter int unsigned MAX_FAIL  = LOCK_MAX_FAIL
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      kb_data,
    input  logic                            kb_valid,
    output logic                            kb_ready,
    input  logic                            key_clear,
    output logic [KEY_WIDTH-1:0]            key_out,
    output logic                            key_loaded,
    output logic                            load_err,
    output logic                            lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int unsigned NBYTES = KEY_WIDTH / 8;
    localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned FW     = $clog2(MAX_FAIL + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    lock_state_e            state;
    logic [KEY_WIDTH-1:0]   shadow;
    logic [CW-1:0]          byte_cnt;

    logic                   open_state;
    logic                   clear_hit;
    logic                   accept;
    logic [CW-1:0]          beat_idx;
    logic                   last_beat;
    logic [KEY_WIDTH-1:0]   shadow_upd;

`ifdef LOCK_KEY_CHECKSUM_EN
    logic                   acc_clr;
    logic                   acc_en;
    logic [7:0]             acc;
    logic                   load_err_q;
    logic                   lockout_q;
    logic [FW-1:0]          fail_cnt_q;
    logic [FW-1:0]          fail_inc;
`endif

    // Handshake, clear qualification and shadow merge of the incoming byte
    always_comb begin
        open_state = (state == ST_IDLE) || (state == ST_LOAD);
`ifdef LOCK_KEY_CHECKSUM_EN
        open_state = open_state || (state == ST_CHECK);
`endif
        clear_hit  = key_clear && (state != ST_LOCKOUT);
        kb_ready   = open_state && !clear_hit;
        accept     = kb_valid && kb_ready;
        beat_idx   = (state == ST_LOAD) ? byte_cnt : '0;
        last_beat  = (beat_idx == LAST_IDX);
        shadow_upd = shadow;
        shadow_upd[{beat_idx, 3'b000} +: 8] = kb_data;
    end

`ifdef LOCK_KEY_CHECKSUM_EN
    // Accumulator restarts in IDLE and on clear; it folds in key bytes only
    always_comb begin
        acc_clr  = (state == ST_IDLE) || clear_hit;
        acc_en   = accept && (state != ST_CHECK);
        fail_inc = FW'(fail_cnt_q + 1'b1);
    end

    lock_key_xor_acc u_xor_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .din (kb_data),
        .acc (acc)
    );

    assign load_err = load_err_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign load_err = 1'b0;
    assign lockout  = 1'b0;
    assign fail_cnt = FW'(0);
`endif

    // Loader FSM with shadow register and key commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            byte_cnt   <= '0;
            key_out    <= '0;
            key_loaded <= 1'b0;
`ifdef LOCK_KEY_CHECKSUM_EN
            load_err_q <= 1'b0;
            lockout_q  <= 1'b0;
            fail_cnt_q <= '0;
`endif
        end else begin
`ifdef LOCK_KEY_CHECKSUM_EN
            load_err_q <= 1'b0;
`endif
            if (clear_hit) begin
                state      <= ST_IDLE;
                shadow     <= '0;
                byte_cnt   <= '0;
                key_out    <= '0;
                key_loaded <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_LOAD: begin
                        if (accept) begin
                            shadow <= shadow_upd;
                            if (last_beat) begin
`ifdef LOCK_KEY_CHECKSUM_EN
                                state      <= ST_CHECK;
`else
                                state      <= ST_LOADED;
                                key_out    <= shadow_upd;
                                key_loaded <= 1'b1;
`endif
                            end else begin
                                state    <= ST_LOAD;
                                byte_cnt <= CW'(beat_idx + 1'b1);
                            end
                        end
                    end
`ifdef LOCK_KEY_CHECKSUM_EN
                    ST_CHECK: begin
                        if (accept) begin
                            byte_cnt <= '0;
                            if (kb_data == acc) begin
                                state      <= ST_LOADED;
                                key_out    <= shadow;
                                key_loaded <= 1'b1;
                                fail_cnt_q <= '0;
                            end else begin
                                shadow     <= '0;
                                key_out    <= '0;
                                key_loaded <= 1'b0;
                                load_err_q <= 1'b1;
                                fail_cnt_q <= fail_inc;
                                if (fail_inc == FW'(MAX_FAIL)) begin
                                    state     <= ST_LOCKOUT;
                                    lockout_q <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
`endif
                    ST_LOADED: begin
                        // Key held; input ignored until clear
                    end
                    ST_LOCKOUT: begin
                        key_out    <= '0;
                        key_loaded <= 1'b0;
`ifdef LOCK_KEY_CHECKSUM_EN
                        lockout_q  <= 1'b1;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader. Expected behaviour comes from a
// transaction-level model: a queue of accepted bytes that is packed into a
// key once a full load (plus checksum when LOCK_KEY_CHECKSUM_EN) arrives.
module tb_lock_key_loader;
    import lock_pkg::*;

    localparam int unsigned KW = 64;
    localparam int unsigned NB = 8;
    localparam int unsigned MF = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    kb_data;
    logic          kb_valid;
    logic          kb_ready;
    logic          key_clear;
    logic [KW-1:0] key_out;
    logic          key_loaded;
    logic          load_err;
    logic          lockout;
    logic [1:0]    fail_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]    m_q[$];
    logic [KW-1:0] m_key;
    bit            m_loaded;
    bit            m_lock;
    bit            m_err;
    int            m_fail;

    lock_key_loader #(.KEY_WIDTH(KW), .MAX_FAIL(MF)) dut (
        .clk        (clk),
        .rst        (rst),
        .kb_data    (kb_data),
        .kb_valid   (kb_valid),
        .kb_ready   (kb_ready),
        .key_clear  (key_clear),
        .key_out    (key_out),
        .key_loaded (key_loaded),
        .load_err   (load_err),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_key    = '0;
        m_loaded = 1'b0;
        m_lock   = 1'b0;
        m_err    = 1'b0;
        m_fail   = 0;
    endtask

    // Effect of one clock edge on the model, given pre-edge inputs
    task automatic model_edge(input logic v, input logic [7:0] d, input logic clr, input logic rdy);
        logic [7:0] x;
        m_err = 1'b0;
        if (m_lock) begin
            // only reset leaves lockout
        end else if (clr) begin
            m_q.delete();
            m_key    = '0;
            m_loaded = 1'b0;
        end else if (v && rdy) begin
            m_q.push_back(d);
`ifdef LOCK_KEY_CHECKSUM_EN
            if (m_q.size() == NB + 1) begin
                x = 8'h00;
                for (int i = 0; i < NB; i++) x ^= m_q[i];
                if (m_q[NB] == x) begin
                    for (int i = 0; i < NB; i++) m_key[8*i +: 8] = m_q[i];
                    m_loaded = 1'b1;
                    m_fail   = 0;
                end else begin
                    m_err = 1'b1;
                    m_fail++;
                    if (m_fail == MF) m_lock = 1'b1;
                end
                m_q.delete();
            end
`else
            x = 8'h00;
            if (m_q.size() == NB) begin
                for (int i = 0; i < NB; i++) m_key[8*i +: 8] = m_q[i];
                m_loaded = 1'b1;
                m_q.delete();
            end
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".key_out"},    key_out,          m_key);
        check({tag, ".key_loaded"}, KW'(key_loaded),  KW'(m_loaded));
`ifdef LOCK_KEY_CHECKSUM_EN
        check({tag, ".load_err"},   KW'(load_err),    KW'(m_err));
        check({tag, ".lockout"},    KW'(lockout),     KW'(m_lock));
        check({tag, ".fail_cnt"},   KW'(fail_cnt),    KW'(m_fail));
`else
        check({tag, ".load_err"},   KW'(load_err),    KW'(0));
        check({tag, ".lockout"},    KW'(lockout),     KW'(0));
        check({tag, ".fail_cnt"},   KW'(fail_cnt),    KW'(0));
`endif
    endtask

    // One cycle: drive at edge+1, check ready, clock, check outputs at edge+1
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic clr);
        logic rdy;
        kb_valid  = v;
        kb_data   = d;
        key_clear = clr;
        #1;
        rdy = !m_loaded && !m_lock && !clr;
        check({tag, ".kb_ready"}, KW'(kb_ready), KW'(rdy));
        @(posedge clk);
        model_edge(v, d, clr, rdy);
        #1;
        check_outputs(tag);
        kb_valid  = 1'b0;
        key_clear = 1'b0;
    endtask

    // Full key load, LSB first, optional idle cycles; checksum byte when enabled
    task automatic load_key(input string tag, input logic [KW-1:0] k, input bit gaps);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (gaps) step(tag, 1'b0, 8'h5A, 1'b0);
            b = k[8*i +: 8];
            x ^= b;
            step(tag, 1'b1, b, 1'b0);
        end
`ifdef LOCK_KEY_CHECKSUM_EN
        if (gaps) step(tag, 1'b0, 8'h5A, 1'b0);
        step(tag, 1'b1, x, 1'b0);
`else
        b = x;
`endif
    endtask

    // Reset asserted between edges; outputs must drop before the next edge
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs({tag, ".release"});
    endtask

    logic [KW-1:0] rk;
    logic [KW-1:0] seq_key;
    int            nb;

    initial begin
        rst       = 1'b0;
        kb_data   = 8'h00;
        kb_valid  = 1'b0;
        key_clear = 1'b0;
        model_reset();
        seq_key = 64'h0807060504030201;

        // Outputs zero under reset before any clock edge
        #2;
        check_outputs("reset");
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        // Back-to-back load
        load_key("b2b", seq_key, 1'b0);
        check("b2b.key_lit", key_out, 64'h0807060504030201);
        check("b2b.kb_ready_loaded", KW'(kb_ready), KW'(0));

        // LOADED ignores bytes; clear together with valid wins
        step("loaded_ign", 1'b1, 8'hFF, 1'b0);
        step("clr_loaded", 1'b1, 8'h77, 1'b1);
        check("clr_loaded.key_lit", key_out, 64'h0);

        // Load with idle gaps
        load_key("gaps", seq_key, 1'b1);
        check("gaps.key_lit", key_out, 64'h0807060504030201);
        step("gaps_clr", 1'b0, 8'h00, 1'b1);

        // Partial load, clear, then a fresh load
        step("part", 1'b1, 8'h11, 1'b0);
        step("part", 1'b1, 8'h22, 1'b0);
        step("part", 1'b1, 8'h33, 1'b0);
        step("part_clr", 1'b0, 8'h00, 1'b1);
        load_key("a8", 64'h00000000000000A8, 1'b0);
        check("a8.key_lit", key_out, 64'h00000000000000A8);
        check("a8.alu_slice", KW'(alu_key_slice(key_out)), KW'(8'hA8));
        step("a8_clr", 1'b0, 8'h00, 1'b1);

        // Clear with simultaneous valid in LOAD drops the byte
        step("clr_load", 1'b1, 8'h44, 1'b0);
        step("clr_load", 1'b1, 8'h55, 1'b1);
        load_key("after_clr", 64'hF0E1D2C3B4A59687, 1'b0);
        check("after_clr.key_lit", key_out, 64'hF0E1D2C3B4A59687);

        // Randomised loads with gaps, stray bytes and occasional aborts
        for (int it = 0; it < 16; it++) begin
            step("rnd_clr", 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            rk = {$urandom(), $urandom()};
            nb = (it % 4 == 3) ? int'($urandom_range(1, NB - 1)) : NB;
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) step("rnd_gap", 1'b0, 8'($urandom), 1'b0);
                step("rnd", 1'b1, rk[8*i +: 8], 1'b0);
            end
            if (nb == NB) begin
`ifdef LOCK_KEY_CHECKSUM_EN
                begin
                    logic [7:0] x;
                    x = 8'h00;
                    for (int i = 0; i < NB; i++) x ^= rk[8*i +: 8];
                    step("rnd_ck", 1'b1, x, 1'b0);
                end
`endif
                check("rnd.key_full", key_out, rk);
                step("rnd_ign", 1'b1, 8'($urandom), 1'b0);
            end else begin
                check("rnd.key_partial", key_out, 64'h0);
            end
        end

`ifdef LOCK_KEY_CHECKSUM_EN
        // Good checksum, then three bad ones into lockout
        step("ck_clr", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < NB; i++) step("ck_good", 1'b1, seq_key[8*i +: 8], 1'b0);
        step("ck_good_sum", 1'b1, 8'h08, 1'b0);
        check("ck_good.key_lit", key_out, 64'h0807060504030201);
        step("ck_clr2", 1'b0, 8'h00, 1'b1);
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < NB; i++) step("ck_bad", 1'b1, seq_key[8*i +: 8], 1'b0);
            step("ck_bad_sum", 1'b1, 8'h00, 1'b0);
            check("ck_bad.load_err", KW'(load_err), KW'(1));
            check("ck_bad.fail_cnt", KW'(fail_cnt), KW'(f));
        end
        check("lock.lockout", KW'(lockout), KW'(1));
        step("lock_clr", 1'b1, 8'h01, 1'b1);
        check("lock_clr.lockout", KW'(lockout), KW'(1));
        async_reset("lock_rst");
`endif

        // Asynchronous reset in the middle of a load, then a fresh load
        step("mid", 1'b1, 8'hDE, 1'b0);
        step("mid", 1'b1, 8'hAD, 1'b0);
        step("mid", 1'b1, 8'hBE, 1'b0);
        async_reset("mid_rst");
        load_key("fresh", seq_key, 1'b0);
        check("fresh.key_lit", key_out, 64'h0807060504030201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
